bnn_maxpool2x2: RTL
===================

Name: bnn_maxpool2x2

Overview:
- Downstream stage of the first binary convolution layer.
- Consumes the raster-ordered signed 8-bit convolution stream: one value per valid cycle, IMG_W x IMG_H values per frame.
- Performs 2x2 stride-2 max pooling and emits an (IMG_W/2) x (IMG_H/2) signed stream to the next layer.
- Buffers one half-row of partial maxima between even and odd rows.

Parameters:
- IMG_W, 32, conv output width in pixels; must be even and at least 2.
- IMG_H, 32, conv output height in rows; must be even and at least 2.
- DW, 8, data width; signed two's complement.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- Frame_Start  input  1  synchronous frame restart; clears position counters.
- Din_Valid  input  1  Din carries a valid conv result this cycle.
- Din  input  DW  signed conv result.
- Dout_Valid  output  1  Dout carries a valid pooled result this cycle.
- Dout  output  DW  signed pooled result.
- Frame_Done  output  1  one-cycle pulse coincident with the last pooled output of a frame.

Behaviour:
- Reset (async, rst=1): col=0, row=0, hold register=0, every half-row buffer entry=0, Dout=0, Dout_Valid=0, Frame_Done=0.
- Reset asserted mid-frame aborts the frame. The first valid after reset release is pixel (0,0).
- Position counters:
  - col runs 0..IMG_W-1 and advances only on Din_Valid.
  - When col wraps, row increments, running 0..IMG_H-1.
  - When row wraps, the next frame begins at (0,0).
  - Din_Valid=0 cycles are bubbles: no state change, Dout_Valid=0.
- Frame_Start=1 forces col=0 and row=0.
  - If Din_Valid=1 in the same cycle, that pixel is processed as (0,0) of the new frame.
  - The half-row buffer is not cleared; it is overwritten by the next even row.
- Even row, even col: hold <= Din.
- Even row, odd col: buf[col>>1] <= smax(hold, Din).
- Odd row, even col: hold <= Din.
- Odd row, odd col:
  - Dout <= smax(buf[col>>1], hold, Din).
  - Dout_Valid <= 1.
- smax is a signed comparison over DW bits. No width growth: the result is one of the inputs.
- Latency: Dout registers on the edge after the odd-row, odd-col input is sampled, i.e. Dout_Valid is high in the cycle after that input.
- Dout holds its last value when Dout_Valid=0. Dout_Valid is a single-cycle pulse per pooled pixel.
- Frame_Done=1 in the same cycle as the Dout_Valid for input (IMG_H-1, IMG_W-1).
- Throughput: one input per cycle sustained. No backpressure; the downstream must accept every Dout_Valid.
- Output count per frame: exactly (IMG_W/2)*(IMG_H/2).
- Half-row buffer: IMG_W/2 entries of DW bits, written and read only at odd columns.
  - May be implemented as registers or distributed RAM.
  - The read in an odd row returns the value written in the preceding even row.
- Counter widths: $clog2(IMG_W) and $clog2(IMG_H), minimum 1.

Optional Feature:
- Macro: BNN_MAXPOOL_RELU_EN.
- When defined, the registered pooled value is clamped: if it is negative, Dout=0, otherwise the pooled value. The comparison still uses signed maxima before the clamp.
- When undefined, Dout is the raw signed maximum and negative values pass unchanged.
- Timing, Dout_Valid and Frame_Done are identical in both builds.

Test Plan:
- Pooling order: ramp frame with Din=(row*32+col) mod 128 as signed, continuous valid, IMG_W=IMG_H=32.
  - Required: 256 Dout_Valid pulses.
  - First output 33 (window 0,1,32,33), second 35.
  - Frame_Done exactly once, with the 256th output.
- Signed max: window -5, -100, -1, -128 at (0,0),(0,1),(1,0),(1,1); all other pixels -128.
  - Required: first Dout=-1.
  - With BNN_MAXPOOL_RELU_EN defined: first Dout=0.
  - All other outputs -128, or 0 with RELU.
- Bubbles: same ramp with Din_Valid toggled 1,0,1,0.
  - Required: output values identical to continuous streaming.
  - Each Dout_Valid one cycle after its odd/odd input.
  - No Dout_Valid during idle stretches.
- Frame_Start mid-frame: restart at row 5, col 7; the next input (Din=127) arrives with Frame_Start=1 and is pixel (0,0).
  - Required: following outputs match a fresh frame.
  - Exactly 256 outputs before the next Frame_Done.
- Async reset mid-row: assert rst at row 1, col 9 between clock edges.
  - Required: Dout=0, Dout_Valid=0 and Frame_Done=0 immediately.
  - The subsequent frame produces correct 256 outputs.
- Back-to-back frames: two ramp frames with no gap.
  - Required: Frame_Done pulses 256 outputs apart.
  - The first output of frame 2 is 33; no stale buffer data is used.

Source files
------------

// File: rtl/bnn_maxpool2x2.sv
// 2x2 stride-2 signed max pooling over a raster-ordered conv stream; one half-row of partial maxima is buffered.
// Optional macro BNN_MAXPOOL_RELU_EN clamps negative pooled results to zero.
module bnn_maxpool2x2 #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int DW    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Frame_Start,
  input  logic                 Din_Valid,
  input  logic signed [DW-1:0] Din,
  output logic                 Dout_Valid,
  output logic signed [DW-1:0] Dout,
  output logic                 Frame_Done
);

  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int HW = IMG_W / 2;
  localparam int BW = (HW > 1) ? $clog2(HW) : 1;

  logic [CW-1:0]        col, col_eff;
  logic [RW-1:0]        row, row_eff;
  logic [BW-1:0]        bidx;
  logic                 col_last, row_last;
  logic signed [DW-1:0] hold;
  logic signed [DW-1:0] hbuf [HW];
  logic signed [DW-1:0] pair_max, pool_max, pool_out;

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Frame_Start makes the pixel arriving in the same cycle position (0,0).
  always_comb begin
    col_eff  = Frame_Start ? '0 : col;
    row_eff  = Frame_Start ? '0 : row;
    col_last = (col_eff == CW'(IMG_W - 1));
    row_last = (row_eff == RW'(IMG_H - 1));
    bidx     = BW'(col_eff >> 1);
    pair_max = smax(hold, Din);
    pool_max = smax(hbuf[bidx], pair_max);
`ifdef BNN_MAXPOOL_RELU_EN
    pool_out = pool_max[DW-1] ? '0 : pool_max;
`else
    pool_out = pool_max;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      hold       <= '0;
      Dout       <= '0;
      Dout_Valid <= 1'b0;
      Frame_Done <= 1'b0;
      for (int i = 0; i < HW; i++) hbuf[i] <= '0;
    end else begin
      Dout_Valid <= 1'b0;
      Frame_Done <= 1'b0;
      if (Din_Valid) begin
        col <= col_last ? '0 : col_eff + CW'(1);
        if (col_last) row <= row_last ? '0 : row_eff + RW'(1);
        else          row <= row_eff;
        if (!col_eff[0]) begin
          hold <= Din;
        end else if (!row_eff[0]) begin
          hbuf[bidx] <= pair_max;
        end else begin
          Dout       <= pool_out;
          Dout_Valid <= 1'b1;
          Frame_Done <= row_last && col_last;
        end
      end else if (Frame_Start) begin
        col <= '0;
        row <= '0;
      end
    end
  end

endmodule
